// File: rtl/fetch_decode_register_pkg.sv
// fetch_decode_register_pkg: shared constants and occupancy encoding for the fetch/decode latch
package fetch_decode_register_pkg;
  localparam logic [31:0] NOP_WORD = 32'h00000013;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;
endpackage

// File: rtl/fetch_decode_register_skid_buffer_2.sv
// skid_buffer_2: generic 2-entry valid/ready FIFO with flush; head is always the oldest entry
module skid_buffer_2
  import fetch_decode_register_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);
  occ_t occ, occ_next;
  logic [WIDTH-1:0] head, tail;
  logic push, pop;
  assign in_ready  = occ != OCC_TWO;
  assign out_valid = occ != OCC_EMPTY;
  assign out_data  = head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_comb begin
    occ_next = occ == OCC_EMPTY ? (push ? OCC_ONE : OCC_EMPTY)
             : occ == OCC_ONE   ? (push && !pop ? OCC_TWO : !push && pop ? OCC_EMPTY : OCC_ONE)
             : (pop ? OCC_ONE : OCC_TWO);
  end
  // payload registers need no reset: occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    occ <= (rst || flush) ? OCC_EMPTY : occ_next;
    if (push && (occ == OCC_EMPTY || pop)) head <= in_data;
    else if (pop && occ == OCC_TWO) head <= tail;
    if (push && !pop && occ == OCC_ONE) tail <= in_data;
  end
endmodule

// File: rtl/fetch_decode_register.sv
// fetch_decode_register: fetch->decode latch with 2-entry skid buffer, NOP bubbles and flush.
// Optional stall cycle counter enabled by FETCH_DECODE_STALL_COUNTER_EN.
module fetch_decode_register
  import fetch_decode_register_pkg::*;
#(
  parameter int                    WORD_WIDTH           = 32,
  parameter int                    ADDRESS_WIDTH        = 32,
  parameter int                    REGISTER_INDEX_WIDTH = 5,
  parameter logic [WORD_WIDTH-1:0] NOP_INSTRUCTION      = NOP_WORD
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_valid,
  input  logic [WORD_WIDTH-1:0]           fetch_instruction,
  input  logic [ADDRESS_WIDTH-1:0]        fetch_pc,
  output logic                            fetch_ready,
  input  logic                            stall,
  input  logic                            flush,
  output logic                            decode_valid,
  output logic [WORD_WIDTH-1:0]           decode_instruction,
  output logic [ADDRESS_WIDTH-1:0]        decode_pc,
  output logic [REGISTER_INDEX_WIDTH-1:0] decode_idx_src_1,
  output logic [REGISTER_INDEX_WIDTH-1:0] decode_idx_src_2,
  output logic [31:0]                     stall_cycles
);
  logic [ADDRESS_WIDTH+WORD_WIDTH-1:0] head;
  skid_buffer_2 #(.WIDTH(ADDRESS_WIDTH + WORD_WIDTH)) buffer (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (fetch_valid),
    .in_data  ({fetch_pc, fetch_instruction}),
    .in_ready (fetch_ready),
    .out_valid(decode_valid),
    .out_data (head),
    .out_ready(!stall)
  );
  assign decode_instruction = decode_valid ? head[WORD_WIDTH-1:0] : NOP_INSTRUCTION;
  assign decode_pc          = decode_valid ? head[ADDRESS_WIDTH+WORD_WIDTH-1:WORD_WIDTH] : '0;
  assign decode_idx_src_1   = decode_valid ? head[RS1_LSB +: REGISTER_INDEX_WIDTH] : '0;
  assign decode_idx_src_2   = decode_valid ? head[RS2_LSB +: REGISTER_INDEX_WIDTH] : '0;
`ifdef FETCH_DECODE_STALL_COUNTER_EN
  logic [31:0] count;
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (decode_valid && stall && !(&count)) count <= count + 32'd1;
  end
  assign stall_cycles = count;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_fetch_decode_register.sv
// tb_fetch_decode_register: directed stimulus with a queue scoreboard checked by a negedge monitor
module tb_fetch_decode_register;
  logic        clk = 0;
  logic        rst, fetch_valid, fetch_ready, stall, flush, decode_valid;
  logic [31:0] fetch_instruction, fetch_pc, decode_instruction, decode_pc, stall_cycles;
  logic [4:0]  decode_idx_src_1, decode_idx_src_2;
  int          checks = 0, failures = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t q[$];
  ent_t e;
`ifdef FETCH_DECODE_STALL_COUNTER_EN
  localparam logic [31:0] STALL_EXP = 32'd7;
  localparam logic [31:0] STALL_MID = 32'd3;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
  localparam logic [31:0] STALL_MID = 32'd0;
`endif
  always #5 clk = ~clk;
  fetch_decode_register dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_valid       (fetch_valid),
    .fetch_instruction (fetch_instruction),
    .fetch_pc          (fetch_pc),
    .fetch_ready       (fetch_ready),
    .stall             (stall),
    .flush             (flush),
    .decode_valid      (decode_valid),
    .decode_instruction(decode_instruction),
    .decode_pc         (decode_pc),
    .decode_idx_src_1  (decode_idx_src_1),
    .decode_idx_src_2  (decode_idx_src_2),
    .stall_cycles      (stall_cycles)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, x);
    end
  endtask
  // drive one cycle; the expected entry is queued only if the push will really happen
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic s, input logic f);
    fetch_valid = v; fetch_instruction = ins; fetch_pc = pc; stall = s; flush = f;
    if (rst || f) q.delete();
    else if (v && fetch_ready) q.push_back('{pc: pc, ins: ins});
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_state(input string n);
    chk({n, "_valid"}, {31'd0, decode_valid}, 32'd0);
    chk({n, "_instr"}, decode_instruction, 32'h00000013);
    chk({n, "_pc"}, decode_pc, 32'd0);
    chk({n, "_rs1"}, {27'd0, decode_idx_src_1}, 32'd0);
    chk({n, "_rs2"}, {27'd0, decode_idx_src_2}, 32'd0);
    chk({n, "_ready"}, {31'd0, fetch_ready}, 32'd1);
    chk({n, "_stall_cycles"}, stall_cycles, 32'd0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (decode_valid) begin
        if (!stall && !flush) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output actual=%h expected=none", decode_pc);
          end else begin
            e = q.pop_front();
            chk("sb_pc", decode_pc, e.pc);
            chk("sb_instr", decode_instruction, e.ins);
            chk("sb_rs1", {27'd0, decode_idx_src_1}, {27'd0, e.ins[19:15]});
            chk("sb_rs2", {27'd0, decode_idx_src_2}, {27'd0, e.ins[24:20]});
          end
        end
      end else begin
        chk("bubble_instr", decode_instruction, 32'h00000013);
        chk("bubble_pc", decode_pc, 32'd0);
        chk("bubble_rs", {22'd0, decode_idx_src_1, decode_idx_src_2}, 32'd0);
      end
    end
  end
  initial begin
    rst = 1; fetch_valid = 0; fetch_instruction = 0; fetch_pc = 0; stall = 0; flush = 0;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    rst = 0;
    chk_reset_state("reset");
    drive(1, 32'h00208133, 32'h100, 0, 0);
    chk("single_valid", {31'd0, decode_valid}, 32'd1);
    chk("single_pc", decode_pc, 32'h100);
    chk("single_rs1", {27'd0, decode_idx_src_1}, 32'd1);
    chk("single_rs2", {27'd0, decode_idx_src_2}, 32'd2);
    drive(0, 0, 0, 0, 0);
    chk("single_drain", {31'd0, decode_valid}, 32'd0);
    drive(1, 32'h00418233, 32'h100, 1, 0);
    drive(1, 32'h0062a2b3, 32'h104, 1, 0);
    chk("full_ready", {31'd0, fetch_ready}, 32'd0);
    chk("stall_head", decode_pc, 32'h100);
    drive(1, 32'h00838333, 32'h108, 1, 0);
    chk("stall_hold_pc", decode_pc, 32'h100);
    chk("stall_hold_instr", decode_instruction, 32'h00418233);
    drive(1, 32'h00838333, 32'h108, 0, 0);
    chk("order_1", decode_pc, 32'h104);
    drive(1, 32'h00838333, 32'h108, 0, 0);
    chk("order_2", decode_pc, 32'h108);
    drive(0, 0, 0, 0, 0);
    chk("order_drain", {31'd0, decode_valid}, 32'd0);
    drive(1, 32'h00a483b3, 32'h200, 1, 0);
    drive(1, 32'h00b50433, 32'h204, 1, 0);
    chk("flush_full", {31'd0, fetch_ready}, 32'd0);
    drive(1, 32'h00c584b3, 32'h208, 1, 1);
    chk("flush_valid", {31'd0, decode_valid}, 32'd0);
    chk("flush_ready", {31'd0, fetch_ready}, 32'd1);
    drive(0, 0, 0, 0, 0);
    chk("flush_absent", {31'd0, decode_valid}, 32'd0);
    drive(1, 32'h00d60533, 32'h300, 0, 0);
    drive(1, 32'h00e685b3, 32'h304, 0, 1);
    chk("flush_push_dropped", {31'd0, decode_valid}, 32'd0);
    drive(1, 32'h00f70633, 32'h400, 1, 0);
    drive(1, 32'h010786b3, 32'h404, 1, 0);
    drive(0, 0, 0, 1, 0);
    rst = 1;
    drive(0, 0, 0, 1, 0);
    rst = 0;
    chk_reset_state("midrst");
    drive(1, 32'h01180733, 32'h500, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    chk("counter_mid", stall_cycles, STALL_MID);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);
    chk("counter_held_head", decode_pc, 32'h500);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    chk("counter_final", stall_cycles, STALL_EXP);
    drive(0, 0, 0, 0, 1);
    chk("counter_after_flush", stall_cycles, STALL_EXP);
    drive(0, 0, 0, 0, 0);
    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
